// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: write port, two read ports and write-error flag of the register file
interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              werr;
  modport master (output we, waddr, wdata, raddr1, raddr2, input rdata1, rdata2, werr);
  modport slave  (input we, waddr, wdata, raddr1, raddr2, output rdata1, rdata2, werr);
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised 2-read/1-write register file with bypass, optional zero r0 and registered read
module regfile_2r1w #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit READ_REG = 1'b0
)(
  input logic           i_clk,
  input logic           i_rst_n,
  regfile_2r1w_if.slave bus
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_rd  [2];
  logic [DATA_W-1:0] w_rd  [2];
  logic [ADDR_W-1:0] w_ra  [2];
  logic              w_wr_oor;
  logic              w_wr_ok;
  logic              r_werr;
  assign w_ra[0]  = bus.raddr1;
  assign w_ra[1]  = bus.raddr2;
  assign w_wr_oor = bus.we && ({1'b0, bus.waddr} >= LIM);
  assign w_wr_ok  = bus.we && !w_wr_oor && !(ZERO_R0 && bus.waddr == '0);
  // Bypass keeps combinational reads write-through and registered reads equal to post-write contents
  always_comb begin
    for (int p = 0; p < 2; p++)
      w_rd[p] = ({1'b0, w_ra[p]} >= LIM || (ZERO_R0 && w_ra[p] == '0)) ? '0 :
                (w_wr_ok && bus.waddr == w_ra[p]) ? bus.wdata : r_mem[w_ra[p][IW-1:0]];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_werr <= 1'b0;
    end else begin
      if (w_wr_ok) r_mem[bus.waddr[IW-1:0]] <= bus.wdata;
      r_werr <= w_wr_oor;
    end
  end
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 2; p++) r_rd[p] <= i_rst_n ? w_rd[p] : '0;
  end
  assign bus.rdata1 = READ_REG ? r_rd[0] : w_rd[0];
  assign bus.rdata2 = READ_REG ? r_rd[1] : w_rd[1];
  assign bus.werr   = r_werr;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed vector bench for a combinational-read and a registered-read instance
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  regfile_2r1w_if #(.DATA_W(16), .ADDR_W(5)) ia ();
  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(3)) ib ();
  regfile_2r1w #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(24), .ZERO_R0(1'b1), .READ_REG(1'b0))
    dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ia));
  regfile_2r1w #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(8), .ZERO_R0(1'b0), .READ_REG(1'b1))
    dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ib));
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ee;
  } vec_t;
  vec_t va [15];
  vec_t vb [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive_a(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
    ia.we = we; ia.waddr = wa; ia.wdata = wd[15:0]; ia.raddr1 = r1; ia.raddr2 = r2;
  endtask
  task automatic drive_b(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
    ib.we = we; ib.waddr = wa[2:0]; ib.wdata = wd; ib.raddr1 = r1[2:0]; ib.raddr2 = r2[2:0];
  endtask
  initial begin
    // combinational instance, NUM_REGS=24, ZERO_R0=1: werr reflects the previous vector's write
    va[0]  = '{1'b1, 5'd1,  32'd15,   5'd1,  5'd3,  32'd15,   32'd0,    1'b0};
    va[1]  = '{1'b1, 5'd3,  32'd10,   5'd1,  5'd3,  32'd15,   32'd10,   1'b0};
    va[2]  = '{1'b0, 5'd0,  32'd0,    5'd1,  5'd3,  32'd15,   32'd10,   1'b0};
    va[3]  = '{1'b1, 5'd5,  32'h00AA, 5'd5,  5'd1,  32'h00AA, 32'd15,   1'b0};
    va[4]  = '{1'b0, 5'd0,  32'd0,    5'd5,  5'd5,  32'h00AA, 32'h00AA, 1'b0};
    va[5]  = '{1'b1, 5'd0,  32'h1234, 5'd0,  5'd5,  32'd0,    32'h00AA, 1'b0};
    va[6]  = '{1'b0, 5'd0,  32'd0,    5'd0,  5'd0,  32'd0,    32'd0,    1'b0};
    va[7]  = '{1'b1, 5'd30, 32'hFFFF, 5'd30, 5'd1,  32'd0,    32'd15,   1'b0};
    va[8]  = '{1'b0, 5'd0,  32'd0,    5'd30, 5'd3,  32'd0,    32'd10,   1'b1};
    va[9]  = '{1'b0, 5'd0,  32'd0,    5'd1,  5'd5,  32'd15,   32'h00AA, 1'b0};
    va[10] = '{1'b1, 5'd23, 32'h0BEE, 5'd23, 5'd24, 32'h0BEE, 32'd0,    1'b0};
    va[11] = '{1'b1, 5'd24, 32'd5,    5'd23, 5'd24, 32'h0BEE, 32'd0,    1'b0};
    va[12] = '{1'b1, 5'd31, 32'd6,    5'd24, 5'd3,  32'd0,    32'd10,   1'b1};
    va[13] = '{1'b0, 5'd0,  32'd0,    5'd3,  5'd1,  32'd10,   32'd15,   1'b1};
    va[14] = '{1'b0, 5'd0,  32'd0,    5'd23, 5'd30, 32'h0BEE, 32'd0,    1'b0};
    // registered instance, 32-bit, 8 regs, ZERO_R0=0: expectations are the values after the edge
    vb[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vb[1]  = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd7, 32'h1234,     32'hDEADBEEF, 1'b0};
    vb[2]  = '{1'b0, 5'd0, 32'd0,        5'd0, 5'd7, 32'h1234,     32'hDEADBEEF, 1'b0};
    vb[3]  = '{1'b1, 5'd3, 32'hCAFE0001, 5'd3, 5'd7, 32'hCAFE0001, 32'hDEADBEEF, 1'b0};
    vb[4]  = '{1'b0, 5'd0, 32'd0,        5'd3, 5'd3, 32'hCAFE0001, 32'hCAFE0001, 1'b0};
    rst_n = 1'b0;
    drive_a(1'b0, 5'd0, 32'd0, 5'd1, 5'd3);
    drive_b(1'b0, 5'd0, 32'd0, 5'd1, 5'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a.rd1", ia.rdata1, 32'd0);
    chk("rst.a.rd2", ia.rdata2, 32'd0);
    chk("rst.a.werr", ia.werr, 32'd0);
    chk("rst.b.rd1", ib.rdata1, 32'd0);
    chk("rst.b.rd2", ib.rdata2, 32'd0);
    chk("rst.b.werr", ib.werr, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive_a(va[i].we, va[i].wa, va[i].wd, va[i].r1, va[i].r2);
      @(negedge clk);
      chk($sformatf("a%0d.rd1", i), ia.rdata1, va[i].e1);
      chk($sformatf("a%0d.rd2", i), ia.rdata2, va[i].e2);
      chk($sformatf("a%0d.werr", i), ia.werr, va[i].ee);
      @(posedge clk);
      #1;
    end
    // reset beats a simultaneous write, and a bad write in reset raises no werr
    drive_a(1'b1, 5'd2, 32'd7, 5'd2, 5'd1);
    @(posedge clk);
    #1;
    drive_a(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    #1;
    chk("prio.r2pre", ia.rdata1, 32'd7);
    rst_n = 1'b0;
    drive_a(1'b1, 5'd2, 32'd9, 5'd2, 5'd1);
    @(posedge clk);
    #1;
    drive_a(1'b1, 5'd30, 32'hFFFF, 5'd2, 5'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_a(1'b0, 5'd0, 32'd0, 5'd2, 5'd1);
    @(negedge clk);
    chk("prio.r2", ia.rdata1, 32'd0);
    chk("prio.r1", ia.rdata2, 32'd0);
    chk("prio.werr", ia.werr, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      drive_b(vb[i].we, vb[i].wa, vb[i].wd, vb[i].r1, vb[i].r2);
      @(posedge clk);
      #1;
      chk($sformatf("b%0d.rd1", i), ib.rdata1, vb[i].e1);
      chk($sformatf("b%0d.rd2", i), ib.rdata2, vb[i].e2);
      chk($sformatf("b%0d.werr", i), ib.werr, vb[i].ee);
    end
    // registered read holds until the next edge
    drive_b(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    #2;
    chk("lat.hold", ib.rdata1, 32'hCAFE0001);
    @(posedge clk);
    #1;
    chk("lat.rd1", ib.rdata1, 32'hDEADBEEF);
    chk("lat.rd2", ib.rdata2, 32'h1234);
    rst_n = 1'b0;
    drive_b(1'b1, 5'd7, 32'h55555555, 5'd7, 5'd0);
    @(posedge clk);
    #1;
    chk("brst.rd1", ib.rdata1, 32'd0);
    chk("brst.rd2", ib.rdata2, 32'd0);
    rst_n = 1'b1;
    drive_b(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    @(posedge clk);
    #1;
    chk("brst.r7", ib.rdata1, 32'd0);
    chk("brst.r0", ib.rdata2, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
